mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single synchronous-read memory port between the fetch stage (instruction requests) and the memory stage (data loads/stores). Each cycle it grants one requester and drives the memory. It routes the one-cycle-late read data back to the requester that issued it. It stalls the loser and bounds fetch starvation with a deferral counter. It sits between `fetch_stage`/memory stage and the unified RAM.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `MAX_DEFER`, 3, consecutive cycles fetch may be denied before it is force-granted (1..15)

- `i_clk`  in  1  clock
- `i_reset`  in  1  synchronous, active-high reset
- `fetch_req_addr`  in  ADDR_W  fetch address
- `fetch_req_stb`  in  1  fetch request
- `fetch_flush`  in  1  drop any in-flight fetch response (branch redirect)
- `fetch_stall`  out  1  fetch request not granted this cycle
- `fetch_rsp_data`  out  DATA_W  fetch read data
- `fetch_rsp_valid`  out  1  fetch read data valid
- `data_req_addr`  in  ADDR_W  data address
- `data_req_stb`  in  1  data request
- `data_req_we`  in  1  1 = store, 0 = load
- `data_req_wdata`  in  DATA_W  store data
- `data_stall`  out  1  data request not granted this cycle
- `data_rsp_data`  out  DATA_W  load data (0 for store acks)
- `data_rsp_valid`  out  1  load data valid / store ack
- `mem_addr`  out  ADDR_W  memory address
- `mem_we`  out  1  memory write enable
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data, valid the cycle after `mem_addr`

## Operation
- Grant (combinational, per cycle):
  - `grant_data = data_req_stb && !(fetch_req_stb && defer_cnt == MAX_DEFER)`.
  - `grant_fetch = fetch_req_stb && !grant_data`.
  - Data has priority unless fetch has been starved for `MAX_DEFER` cycles.
- Memory drive:
  - When data is granted: `mem_addr=data_req_addr`, `mem_we=data_req_we`, `mem_wdata=data_req_wdata`.
  - When fetch is granted: `mem_addr=fetch_req_addr`, `mem_we=0`.
  - When nothing is granted: `mem_addr=0`, `mem_we=0`, `mem_wdata=0`.
- Stalls (combinational):
  - `fetch_stall = fetch_req_stb && !grant_fetch`.
  - `data_stall = data_req_stb && !grant_data`.
  - A requester holds addr/data stable while stalled.
- `defer_cnt`: 4-bit register.
  - Increments (saturating at `MAX_DEFER`) when `fetch_req_stb && !grant_fetch`.
  - Clears when fetch is granted or `fetch_req_stb` is 0.
- Response owner register `rsp_owner` has states NONE, FETCH, DATA_RD, DATA_WR. It loads from the grant each cycle:
  - Data load granted → DATA_RD.
  - Data store granted → DATA_WR.
  - Fetch granted → FETCH.
  - Otherwise → NONE.
- Response outputs (driven from `rsp_owner` and `mem_rdata`):
  - `fetch_rsp_valid = (rsp_owner==FETCH) && !flush_q`. `fetch_rsp_data = mem_rdata` when valid, else 0.
  - `data_rsp_valid = rsp_owner ∈ {DATA_RD, DATA_WR}`. `data_rsp_data = mem_rdata` for DATA_RD, else 0.
- Flush:
  - `flush_q` registers `fetch_flush`.
  - A fetch granted in the same cycle `fetch_flush` is high has its response suppressed the following cycle.
  - Flush never affects data responses or the current grant.
- Simultaneous data store and fetch: the store wins (unless forced). The fetch stalls; no read-after-write bypass is needed because the grants are in different cycles.

## Timing
- Grant and stall: 0-cycle (same cycle as strobe).
- Read response latency: exactly 1 cycle after grant; the valid flag is a single-cycle pulse per grant.
- Store ack: `data_rsp_valid` pulses 1 cycle after the grant, with `data_rsp_data = 0`.
- Back-to-back grants to the same requester: one response per cycle, in order.
- Reset (any cycle, including mid-operation):
  - Next cycle: `rsp_owner=NONE`, `defer_cnt=0`, `flush_q=0`.
  - Therefore `fetch_rsp_valid=0` and `data_rsp_valid=0`; any in-flight response is discarded.
  - During a reset cycle `mem_we` is forced to 0 and no owner is recorded.
- Starvation bound:
  - With `data_req_stb` held high and fetch requesting, fetch is granted at most every `MAX_DEFER+1` cycles.
  - The forced-grant cycle stalls data.

## Test plan
- Fetch only: addresses 0x100, 0x104, 0x108 on consecutive cycles, RAM holds 0xA0,0xA4,0xA8 → `fetch_stall=0`; `fetch_rsp_valid` high cycles 1-3 with data 0xA0,0xA4,0xA8.
- Contention: data load 0x200 and fetch 0x100 both strobe in the same cycle → data granted (`mem_addr=0x200`), `fetch_stall=1`; next cycle `data_rsp_valid=1` with data = mem[0x200]; fetch is granted that cycle.
- Starvation with `MAX_DEFER=3`: data strobes continuously and fetch strobes continuously → fetch granted on cycles 3, 7, 11; `data_stall=1` exactly on those cycles.
- Store: `data_req_we=1`, addr 0x300, wdata 0xDEAD → `mem_we=1`, `mem_wdata=0xDEAD`; next cycle `data_rsp_valid=1`, `data_rsp_data=0`. A subsequent load of 0x300 returns 0xDEAD.
- Flush: fetch granted at 0x100 with `fetch_flush=1` in the same cycle → next cycle `fetch_rsp_valid=0`. A concurrent data response is unaffected.
- Reset mid-operation: assert `i_reset` the cycle after a fetch grant → both rsp_valid outputs are 0 the following cycle; `defer_cnt` reads 0 (the first contention after reset gives data the grant).

Source files
------------

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one synchronous-read memory port between the fetch stage and the
// memory (load/store) stage. Every cycle at most one requester is granted and
// drives the RAM. The read data, which returns one cycle after the address,
// is steered back to whoever was granted the previous cycle. Data requests
// normally win. A deferral counter force-grants fetch after it has been
// denied MAX_DEFER cycles in a row, which bounds fetch starvation.
//
// Parameters
//   ADDR_W     address width
//   DATA_W     data width
//   MAX_DEFER  consecutive denied fetch cycles before fetch is forced (1..15)
//
// Ports
//   i_clk, i_reset                 clock, synchronous active-high reset
//   fetch_req_addr/_stb            fetch request (held stable while stalled)
//   fetch_flush                    suppress the response of a fetch granted now
//   fetch_stall                    fetch requested but not granted this cycle
//   fetch_rsp_data/_valid          fetch read response (1 cycle after grant)
//   data_req_addr/_stb/_we/_wdata  data load/store request
//   data_stall                     data requested but not granted this cycle
//   data_rsp_data/_valid           load data or store ack (data 0 for stores)
//   mem_addr/_we/_wdata            memory command for the granted requester
//   mem_rdata                      memory read data, one cycle after mem_addr
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_DEFER = 3
) (
  input  logic              i_clk,
  input  logic              i_reset,

  input  logic [ADDR_W-1:0] fetch_req_addr,
  input  logic              fetch_req_stb,
  input  logic              fetch_flush,
  output logic              fetch_stall,
  output logic [DATA_W-1:0] fetch_rsp_data,
  output logic              fetch_rsp_valid,

  input  logic [ADDR_W-1:0] data_req_addr,
  input  logic              data_req_stb,
  input  logic              data_req_we,
  input  logic [DATA_W-1:0] data_req_wdata,
  output logic              data_stall,
  output logic [DATA_W-1:0] data_rsp_data,
  output logic              data_rsp_valid,

  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Who owns the read data that comes back from the RAM this cycle.
  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_FETCH,
    OWN_DATA_RD,
    OWN_DATA_WR
  } rsp_owner_e;

  localparam logic [3:0] MAX_DEFER_C = 4'(MAX_DEFER);

  logic       grant_data;
  logic       grant_fetch;
  logic       fetch_forced;

  logic [3:0] defer_cnt_q, defer_cnt_d;
  rsp_owner_e rsp_owner_q, rsp_owner_d;
  logic       flush_q;

  // ---------------------------------------------------------------------------
  // Grant: data first, unless fetch has already waited MAX_DEFER cycles.
  // ---------------------------------------------------------------------------
  assign fetch_forced = fetch_req_stb && (defer_cnt_q == MAX_DEFER_C);
  assign grant_data   = data_req_stb && !fetch_forced;
  assign grant_fetch  = fetch_req_stb && !grant_data;

  assign fetch_stall  = fetch_req_stb && !grant_fetch;
  assign data_stall   = data_req_stb  && !grant_data;

  // ---------------------------------------------------------------------------
  // Memory command. A reset cycle must never write the RAM, whatever the
  // requesters are doing.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the if/else leaves it unassigned and infers a latch.
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (grant_data) begin
      mem_addr  = data_req_addr;
      mem_we    = data_req_we && !i_reset;
      mem_wdata = data_req_wdata;
    end else if (grant_fetch) begin
      mem_addr  = fetch_req_addr;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state: deferral counter and response owner.
  // ---------------------------------------------------------------------------
  always_comb begin
    defer_cnt_d = '0;
    if (fetch_req_stb && !grant_fetch) begin
      defer_cnt_d = (defer_cnt_q >= MAX_DEFER_C) ? MAX_DEFER_C
                                                 : defer_cnt_q + 4'd1;
    end
  end

  always_comb begin
    rsp_owner_d = OWN_NONE;
    if (grant_data) begin
      rsp_owner_d = data_req_we ? OWN_DATA_WR : OWN_DATA_RD;
    end else if (grant_fetch) begin
      rsp_owner_d = OWN_FETCH;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers. Reset drops any in-flight response and forgets how long
  // fetch has been waiting.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (i_reset) begin
      rsp_owner_q <= OWN_NONE;
      defer_cnt_q <= '0;
      flush_q     <= 1'b0;
    end else begin
      rsp_owner_q <= rsp_owner_d;
      defer_cnt_q <= defer_cnt_d;
      flush_q     <= fetch_flush;
    end
  end

  // ---------------------------------------------------------------------------
  // Response steering. flush_q pairs with a fetch granted last cycle, so a
  // redirect kills exactly the response that is now arriving.
  // ---------------------------------------------------------------------------
  always_comb begin
    fetch_rsp_valid = (rsp_owner_q == OWN_FETCH) && !flush_q;
    fetch_rsp_data  = fetch_rsp_valid ? mem_rdata : '0;

    data_rsp_valid  = (rsp_owner_q == OWN_DATA_RD) ||
                      (rsp_owner_q == OWN_DATA_WR);
    data_rsp_data   = (rsp_owner_q == OWN_DATA_RD) ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter. A small RAM behaves like the real
// synchronous-read memory. A behavioural model, which keeps a "cycles fetch
// has waited" count, a shadow of memory contents and the response expected
// next cycle, is compared against the DUT on every falling edge. The stimulus
// process also pins hand-computed literal values at the interesting points.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned MAX_DEFER = 3;

  logic              i_clk;
  logic              i_reset;
  logic [ADDR_W-1:0] fetch_req_addr;
  logic              fetch_req_stb;
  logic              fetch_flush;
  logic              fetch_stall;
  logic [DATA_W-1:0] fetch_rsp_data;
  logic              fetch_rsp_valid;
  logic [ADDR_W-1:0] data_req_addr;
  logic              data_req_stb;
  logic              data_req_we;
  logic [DATA_W-1:0] data_req_wdata;
  logic              data_stall;
  logic [DATA_W-1:0] data_rsp_data;
  logic              data_rsp_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  int tests_run    = 0;
  int tests_failed = 0;

  mem_port_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MAX_DEFER(MAX_DEFER)
  ) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .fetch_req_addr (fetch_req_addr),
    .fetch_req_stb  (fetch_req_stb),
    .fetch_flush    (fetch_flush),
    .fetch_stall    (fetch_stall),
    .fetch_rsp_data (fetch_rsp_data),
    .fetch_rsp_valid(fetch_rsp_valid),
    .data_req_addr  (data_req_addr),
    .data_req_stb   (data_req_stb),
    .data_req_we    (data_req_we),
    .data_req_wdata (data_req_wdata),
    .data_stall     (data_stall),
    .data_rsp_data  (data_rsp_data),
    .data_rsp_valid (data_rsp_valid),
    .mem_addr       (mem_addr),
    .mem_we         (mem_we),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Environment RAM: synchronous read, read-before-write.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] env_ram [logic [ADDR_W-1:0]];

  function automatic logic [DATA_W-1:0] env_read(input logic [ADDR_W-1:0] a);
    return env_ram.exists(a) ? env_ram[a] : '0;
  endfunction

  always @(posedge i_clk) begin
    mem_rdata <= env_read(mem_addr);
    if (mem_we === 1'b1) env_ram[mem_addr] = mem_wdata;
  end

  // ---------------------------------------------------------------------------
  // Behavioural model and per-cycle comparison.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] model_mem [logic [ADDR_W-1:0]];

  function automatic logic [DATA_W-1:0] model_read(input logic [ADDR_W-1:0] a);
    return model_mem.exists(a) ? model_mem[a] : '0;
  endfunction

  bit                model_live = 1'b0;
  int                fetch_waited = 0;
  bit                exp_fv, exp_dv;
  logic [DATA_W-1:0] exp_fd, exp_dd;

  always @(negedge i_clk) begin
    bit                forced, g_data, g_fetch;
    logic [ADDR_W-1:0] e_addr;
    logic              e_we;
    logic [DATA_W-1:0] e_wdata;

    forced  = fetch_req_stb && (fetch_waited >= int'(MAX_DEFER));
    g_data  = data_req_stb && !forced;
    g_fetch = fetch_req_stb && !g_data;

    e_addr = '0; e_we = 1'b0; e_wdata = '0;
    if (g_data) begin
      e_addr = data_req_addr; e_we = data_req_we && !i_reset; e_wdata = data_req_wdata;
    end else if (g_fetch) begin
      e_addr = fetch_req_addr;
    end

    if (model_live) begin
      check("m_fetch_rsp_valid", fetch_rsp_valid, exp_fv);
      check("m_fetch_rsp_data",  fetch_rsp_data,  exp_fd);
      check("m_data_rsp_valid",  data_rsp_valid,  exp_dv);
      check("m_data_rsp_data",   data_rsp_data,   exp_dd);
      check("m_fetch_stall",     fetch_stall, fetch_req_stb && !g_fetch);
      check("m_data_stall",      data_stall,  data_req_stb && !g_data);
      check("m_mem_addr",        mem_addr,  e_addr);
      check("m_mem_we",          mem_we,    e_we);
      check("m_mem_wdata",       mem_wdata, e_wdata);
    end

    if (i_reset) begin
      model_live   = 1'b1;
      fetch_waited = 0;
      exp_fv = 1'b0; exp_fd = '0; exp_dv = 1'b0; exp_dd = '0;
    end else if (model_live) begin
      exp_fv = 1'b0; exp_fd = '0; exp_dv = 1'b0; exp_dd = '0;
      if (g_data && data_req_we) begin
        exp_dv = 1'b1;
        model_mem[data_req_addr] = data_req_wdata;
      end else if (g_data) begin
        exp_dv = 1'b1;
        exp_dd = model_read(data_req_addr);
      end else if (g_fetch && !fetch_flush) begin
        exp_fv = 1'b1;
        exp_fd = model_read(fetch_req_addr);
      end
      if (fetch_req_stb && !g_fetch)
        fetch_waited = (fetch_waited + 1 > int'(MAX_DEFER)) ? int'(MAX_DEFER)
                                                            : fetch_waited + 1;
      else
        fetch_waited = 0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus with literal expectations.
  // ---------------------------------------------------------------------------
  task automatic set_in(input bit f_stb, input logic [31:0] f_addr, input bit flush,
                        input bit d_stb, input bit d_we, input logic [31:0] d_addr,
                        input logic [31:0] d_wdata);
    fetch_req_stb  = f_stb;
    fetch_req_addr = f_addr;
    fetch_flush    = flush;
    data_req_stb   = d_stb;
    data_req_we    = d_we;
    data_req_addr  = d_addr;
    data_req_wdata = d_wdata;
  endtask

  task automatic next_cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    set_in(0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
  endtask

  initial begin
    env_ram[32'h100] = 32'hA0;   model_mem[32'h100] = 32'hA0;
    env_ram[32'h104] = 32'hA4;   model_mem[32'h104] = 32'hA4;
    env_ram[32'h108] = 32'hA8;   model_mem[32'h108] = 32'hA8;
    env_ram[32'h200] = 32'hB200; model_mem[32'h200] = 32'hB200;

    i_reset = 1'b1;
    idle();
    next_cycle();
    @(negedge i_clk);
    check("reset_fetch_rsp_valid", fetch_rsp_valid, 0);
    check("reset_data_rsp_valid",  data_rsp_valid,  0);
    next_cycle();
    i_reset = 1'b0;

    // Fetch only: three consecutive addresses, responses one cycle later.
    set_in(1, 32'h100, 0, 0, 0, 32'h0, 32'h0);
    @(negedge i_clk);
    check("f1_stall", fetch_stall, 0);
    check("f1_mem_addr", mem_addr, 32'h100);
    next_cycle();
    set_in(1, 32'h104, 0, 0, 0, 32'h0, 32'h0);
    @(negedge i_clk);
    check("f2_rsp_valid", fetch_rsp_valid, 1);
    check("f2_rsp_data",  fetch_rsp_data, 32'hA0);
    next_cycle();
    set_in(1, 32'h108, 0, 0, 0, 32'h0, 32'h0);
    @(negedge i_clk);
    check("f3_rsp_data", fetch_rsp_data, 32'hA4);
    next_cycle();
    idle();
    @(negedge i_clk);
    check("f4_rsp_data", fetch_rsp_data, 32'hA8);
    next_cycle();
    @(negedge i_clk);
    check("f5_rsp_valid", fetch_rsp_valid, 0);
    next_cycle();

    // Contention: data load wins, fetch goes the next cycle.
    set_in(1, 32'h100, 0, 1, 0, 32'h200, 32'h0);
    @(negedge i_clk);
    check("c1_mem_addr",    mem_addr, 32'h200);
    check("c1_fetch_stall", fetch_stall, 1);
    check("c1_data_stall",  data_stall, 0);
    next_cycle();
    set_in(1, 32'h100, 0, 0, 0, 32'h0, 32'h0);
    @(negedge i_clk);
    check("c2_data_rsp_valid", data_rsp_valid, 1);
    check("c2_data_rsp_data",  data_rsp_data, 32'hB200);
    check("c2_fetch_stall",    fetch_stall, 0);
    check("c2_mem_addr",       mem_addr, 32'h100);
    next_cycle();
    idle();
    @(negedge i_clk);
    check("c3_fetch_rsp_data", fetch_rsp_data, 32'hA0);
    next_cycle();

    // Starvation: both strobe continuously, fetch forced on cycles 3, 7, 11.
    for (int i = 0; i < 12; i++) begin
      set_in(1, 32'h104, 0, 1, 0, 32'h200, 32'h0);
      @(negedge i_clk);
      check($sformatf("s%0d_data_stall", i),  data_stall,  (i % 4) == 3);
      check($sformatf("s%0d_fetch_stall", i), fetch_stall, (i % 4) != 3);
      next_cycle();
    end
    idle();
    @(negedge i_clk);
    check("s12_fetch_rsp_data", fetch_rsp_data, 32'hA4);
    next_cycle();

    // Store then load-back of the same address.
    set_in(0, 32'h0, 0, 1, 1, 32'h300, 32'hDEAD);
    @(negedge i_clk);
    check("w1_mem_we",    mem_we, 1);
    check("w1_mem_wdata", mem_wdata, 32'hDEAD);
    next_cycle();
    set_in(0, 32'h0, 0, 1, 0, 32'h300, 32'h0);
    @(negedge i_clk);
    check("w2_ack_valid", data_rsp_valid, 1);
    check("w2_ack_data",  data_rsp_data, 32'h0);
    check("w2_mem_we",    mem_we, 0);
    next_cycle();
    idle();
    @(negedge i_clk);
    check("w3_load_data", data_rsp_data, 32'hDEAD);
    next_cycle();

    // Flush: does not touch data responses, kills only the matching fetch.
    set_in(0, 32'h0, 1, 1, 0, 32'h200, 32'h0);
    next_cycle();
    set_in(1, 32'h100, 1, 0, 0, 32'h0, 32'h0);
    @(negedge i_clk);
    check("x1_data_rsp_valid", data_rsp_valid, 1);
    check("x1_data_rsp_data",  data_rsp_data, 32'hB200);
    next_cycle();
    set_in(1, 32'h104, 0, 0, 0, 32'h0, 32'h0);
    @(negedge i_clk);
    check("x2_fetch_rsp_valid", fetch_rsp_valid, 0);
    check("x2_fetch_rsp_data",  fetch_rsp_data, 32'h0);
    next_cycle();
    idle();
    @(negedge i_clk);
    check("x3_fetch_rsp_valid", fetch_rsp_valid, 1);
    check("x3_fetch_rsp_data",  fetch_rsp_data, 32'hA4);
    next_cycle();

    // Reset the cycle after a fetch grant, with a store strobing during reset.
    set_in(1, 32'h108, 0, 0, 0, 32'h0, 32'h0);
    next_cycle();
    i_reset = 1'b1;
    set_in(0, 32'h0, 0, 1, 1, 32'h300, 32'hBEEF);
    @(negedge i_clk);
    check("r1_mem_we", mem_we, 0);
    next_cycle();
    i_reset = 1'b0;
    idle();
    @(negedge i_clk);
    check("r2_fetch_rsp_valid", fetch_rsp_valid, 0);
    check("r2_data_rsp_valid",  data_rsp_valid, 0);
    next_cycle();

    // Build the deferral count to its limit, reset, then contend again.
    for (int i = 0; i < 3; i++) begin
      set_in(1, 32'h108, 0, 1, 0, 32'h200, 32'h0);
      next_cycle();
    end
    i_reset = 1'b1;
    @(negedge i_clk);
    check("r3_data_stall", data_stall, 1);
    next_cycle();
    i_reset = 1'b0;
    @(negedge i_clk);
    check("r4_fetch_rsp_valid", fetch_rsp_valid, 0);
    check("r4_data_rsp_valid",  data_rsp_valid, 0);
    check("r4_data_stall",      data_stall, 0);
    check("r4_mem_addr",        mem_addr, 32'h200);
    next_cycle();
    set_in(0, 32'h0, 0, 1, 0, 32'h300, 32'h0);
    @(negedge i_clk);
    check("r5_data_rsp_data", data_rsp_data, 32'hB200);
    next_cycle();
    idle();
    @(negedge i_clk);
    check("r6_no_reset_write", data_rsp_data, 32'hDEAD);
    next_cycle();
    next_cycle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
